cw305_reg_pmul_gen: RTL and testbench

Parametrised single-clock successor to the ECC point-multiply register block. It holds pNUM_IN host-written operand banks (k, gx, gy by default) and pNUM_OUT core-written result banks (rx, ry by default), all in crypto_clk. It runs a job controller FSM with a start pulse, busy/done/overrun sticky status, an abort control, input locking while a job runs, and a core cycle counter. It sits between the CDC register front-end and the pmul core.

---
 rtl/cw305_pmul_gen_pkg.sv | 46 ++++
 rtl/cw305_word_bank.sv | 67 ++++++
 rtl/cw305_reg_pmul_gen.sv | 251 +++++++++++++++++++++++++
 tb/tb_cw305_reg_pmul_gen.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cw305_pmul_gen_pkg.sv
// Shared constants for the generic point-multiply register block: register map,
// CTRL/STATUS bit positions, job FSM encodings and a width helper.
package cw305_pmul_gen_pkg;

    // Register indices (reg_address values)
    localparam int unsigned RegClkSettings = 32'h00;
    localparam int unsigned RegUserLed     = 32'h01;
    localparam int unsigned RegCryptType   = 32'h02;
    localparam int unsigned RegCryptRev    = 32'h03;
    localparam int unsigned RegIdentify    = 32'h04;
    localparam int unsigned RegCryptGo     = 32'h05;
    localparam int unsigned RegStatus      = 32'h06;
    localparam int unsigned RegCycles      = 32'h07;
    localparam int unsigned RegCtrl        = 32'h08;
    localparam int unsigned RegInBase      = 32'h10;
    localparam int unsigned RegOutBase     = 32'h20;

    // CTRL bit positions
    localparam int unsigned CtrlTrigEn  = 0;
    localparam int unsigned CtrlClrOut  = 1;
    localparam int unsigned CtrlAbort   = 2;

    // STATUS bit positions; Done/Overrun/Aborted are contiguous stickies
    localparam int unsigned StatBusy    = 0;
    localparam int unsigned StatDone    = 1;
    localparam int unsigned StatOverrun = 2;
    localparam int unsigned StatAborted = 3;
    localparam int unsigned StatReady   = 4;

    // Job controller states
    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StStart = 2'd1;
    localparam logic [1:0] StRun   = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    // ceil(log2(n)), never less than 1 so it is always usable as a port width
    function automatic int unsigned clog2w(input int unsigned n);
        int unsigned r;
        r = 1;
        while ((32'd1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/cw305_word_bank.sv
// One operand/result bank: a pOP_WIDTH register with a host byte port, a core word
// port and a synchronous clear. Callers keep indices in range; reads are combinational.
module cw305_word_bank
    import cw305_pmul_gen_pkg::*;
#(
    parameter int unsigned pOP_WIDTH   = 256,
    parameter int unsigned pWORD_WIDTH = 32
) (
    input  logic                                     clk_i,
    input  logic                                     rst_ni,
    input  logic                                     clr_i,
    input  logic                                     byte_we_i,
    input  logic [clog2w(pOP_WIDTH/8)-1:0]           byte_idx_i,
    input  logic [7:0]                               byte_wdata_i,
    output logic [7:0]                               byte_rdata_o,
    input  logic                                     word_we_i,
    input  logic [clog2w(pOP_WIDTH/pWORD_WIDTH)-1:0] word_idx_i,
    input  logic [pWORD_WIDTH-1:0]                   word_wdata_i,
    output logic [pWORD_WIDTH-1:0]                   word_rdata_o
);

    localparam int unsigned Bytes = pOP_WIDTH / 8;
    localparam int unsigned Words = pOP_WIDTH / pWORD_WIDTH;

    logic [pOP_WIDTH-1:0] data_q, data_d;

    // Next state: clear wins; a core word write overrides a host byte write to the same bits
    always_comb begin
        data_d = data_q;
        if (clr_i) begin
            data_d = '0;
        end else begin
            for (int b = 0; b < int'(Bytes); b++) begin
                if (byte_we_i && 32'(byte_idx_i) == 32'(b)) begin
                    data_d[8*b +: 8] = byte_wdata_i;
                end
            end
            for (int w = 0; w < int'(Words); w++) begin
                if (word_we_i && 32'(word_idx_i) == 32'(w)) begin
                    data_d[pWORD_WIDTH*w +: pWORD_WIDTH] = word_wdata_i;
                end
            end
        end
    end

    // Bank storage
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    // Byte and word read muxes; out-of-range indices read as zero
    always_comb begin
        byte_rdata_o = '0;
        word_rdata_o = '0;
        for (int b = 0; b < int'(Bytes); b++) begin
            if (32'(byte_idx_i) == 32'(b)) byte_rdata_o = data_q[8*b +: 8];
        end
        for (int w = 0; w < int'(Words); w++) begin
            if (32'(word_idx_i) == 32'(w)) word_rdata_o = data_q[pWORD_WIDTH*w +: pWORD_WIDTH];
        end
    end

endmodule

// File: rtl/cw305_reg_pmul_gen.sv
// Point-multiply register block: host-written operand banks, core-written result banks,
// job controller (start/busy/done/overrun/abort), input locking and a core cycle counter.
module cw305_reg_pmul_gen
    import cw305_pmul_gen_pkg::*;
#(
    parameter int unsigned pADDR_WIDTH          = 21,
    parameter int unsigned pBYTECNT_SIZE        = 8,
    parameter int unsigned pOP_WIDTH            = 256,
    parameter int unsigned pWORD_WIDTH          = 32,
    parameter int unsigned pNUM_IN              = 3,
    parameter int unsigned pNUM_OUT             = 2,
    parameter int unsigned pDONE_EDGE_SENSITIVE = 1,
    parameter int unsigned pCRYPT_TYPE          = 3,
    parameter int unsigned pCRYPT_REV           = 3,
    parameter logic [7:0]  pIDENTIFY            = 8'h2e
) (
    input  logic                                     crypto_clk,
    input  logic                                     reset_n,
    input  logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0]     reg_address,
    input  logic [pBYTECNT_SIZE-1:0]                 reg_bytecnt,
    input  logic                                     reg_read,
    input  logic                                     reg_write,
    input  logic                                     reg_addrvalid,
    input  logic [7:0]                               write_data,
    output logic [7:0]                               read_data,
    input  logic                                     exttrigger_in,
    input  logic                                     I_ready,
    input  logic                                     I_busy,
    input  logic                                     I_done,
    input  logic [clog2w(pNUM_IN)-1:0]               in_sel,
    input  logic [clog2w(pOP_WIDTH/pWORD_WIDTH)-1:0] in_addr,
    output logic [pWORD_WIDTH-1:0]                   O_in_word,
    input  logic [clog2w(pNUM_OUT)-1:0]              out_sel,
    input  logic [clog2w(pOP_WIDTH/pWORD_WIDTH)-1:0] out_addr,
    input  logic                                     out_wren,
    input  logic [pWORD_WIDTH-1:0]                   I_out_word,
    output logic                                     O_start,
    output logic [4:0]                               O_clksettings,
    output logic                                     O_user_led
);

    localparam int unsigned Words    = pOP_WIDTH / pWORD_WIDTH;
    localparam int unsigned Bytes    = pOP_WIDTH / 8;
    localparam int unsigned NumBanks = pNUM_IN + pNUM_OUT;
    localparam int unsigned ByteIdxW = clog2w(Bytes);

    // Registers
    logic [7:0]             rdata_q, rdata_d;
    logic [pWORD_WIDTH-1:0] in_word_q, in_word_d;
    logic                   start_q, start_d;
    logic [4:0]             clk_q, clk_d;
    logic                   led_q, led_d;
    logic [1:0]             ctrl_q, ctrl_d;     // {clr_out_on_start, trig_en}
    logic [2:0]             sticky_q, sticky_d; // {aborted, overrun, done}
    logic [31:0]            cycles_q, cycles_d;
    logic [1:0]             state_q, state_d;
    logic                   done_in_q;
    logic [2:0]             trig_q;             // two sync flops plus edge history

    // Decoded host access
    logic [31:0]         addr_u;
    logic [31:0]         bytecnt_u;
    logic                wr_en, rd_en, byte0, byte_ok;
    logic [ByteIdxW-1:0] byte_idx;

    assign addr_u    = 32'(reg_address);
    assign bytecnt_u = 32'(reg_bytecnt);
    assign wr_en     = reg_write & reg_addrvalid;
    assign rd_en     = reg_read & reg_addrvalid;
    assign byte0     = (bytecnt_u == 32'd0);
    assign byte_ok   = (bytecnt_u < Bytes);
    assign byte_idx  = ByteIdxW'(reg_bytecnt);

    // Job control events
    logic go_host, trig_rise, go, abort, done_evt, busy, clr_out;
    logic [2:0] stat_clr;
    logic [7:0] status_rd;

    assign go_host   = wr_en && byte0 && addr_u == RegCryptGo;
    assign trig_rise = trig_q[1] & ~trig_q[2];
    assign go        = go_host | (ctrl_q[CtrlTrigEn] & trig_rise);
    assign abort     = wr_en && byte0 && addr_u == RegCtrl && write_data[CtrlAbort];
    assign done_evt  = (pDONE_EDGE_SENSITIVE != 0) ? (I_done & ~done_in_q) : I_done;
    assign busy      = (state_q != StIdle) | I_busy;
    assign clr_out   = (state_q == StStart) & ctrl_q[CtrlClrOut];
    assign stat_clr  = (wr_en && byte0 && addr_u == RegStatus) ?
                       write_data[StatDone +: 3] : 3'b000;
    assign status_rd = {3'b000, I_ready, sticky_q, busy};

    // Bank instances: first pNUM_IN are host-written inputs, the rest core-written results
    logic [7:0]             bank_byte [NumBanks];
    logic [pWORD_WIDTH-1:0] bank_word [NumBanks];

    for (genvar g = 0; g < NumBanks; g++) begin : g_bank
        logic                                     byte_we;
        logic                                     word_we;
        logic                                     clr;
        logic [clog2w(pOP_WIDTH/pWORD_WIDTH)-1:0] word_idx;

        if (g < pNUM_IN) begin : g_in
            // Inputs are locked while a job is in flight
            assign byte_we  = wr_en && byte_ok && addr_u == RegInBase + g && state_q == StIdle;
            assign word_we  = 1'b0;
            assign clr      = 1'b0;
            assign word_idx = in_addr;
        end else begin : g_out
            assign byte_we  = 1'b0;
            assign word_we  = out_wren && 32'(out_sel) == g - pNUM_IN && 32'(out_addr) < Words;
            assign clr      = clr_out;
            assign word_idx = out_addr;
        end

        cw305_word_bank #(
            .pOP_WIDTH   (pOP_WIDTH),
            .pWORD_WIDTH (pWORD_WIDTH)
        ) u_bank (
            .clk_i        (crypto_clk),
            .rst_ni       (reset_n),
            .clr_i        (clr),
            .byte_we_i    (byte_we),
            .byte_idx_i   (byte_idx),
            .byte_wdata_i (write_data),
            .byte_rdata_o (bank_byte[g]),
            .word_we_i    (word_we),
            .word_idx_i   (word_idx),
            .word_wdata_i (I_out_word),
            .word_rdata_o (bank_word[g])
        );
    end

    // Host-writable configuration registers (byte 0 only)
    always_comb begin
        clk_d  = clk_q;
        led_d  = led_q;
        ctrl_d = ctrl_q;
        if (wr_en && byte0) begin
            case (addr_u)
                RegClkSettings: clk_d  = write_data[4:0];
                RegUserLed:     led_d  = write_data[0];
                RegCtrl:        ctrl_d = {write_data[CtrlClrOut], write_data[CtrlTrigEn]};
                default: ;
            endcase
        end
    end

    // Job controller next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (go && I_ready) state_d = StStart;
            StStart: state_d = StRun;
            StRun: begin
                if (done_evt) begin
                    state_d = StDone;
                end else if (abort) begin
                    state_d = StIdle;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Status stickies (set beats clear), cycle counter and start pulse
    always_comb begin
        logic [2:0] set;
        set[0] = (state_q == StDone);
        set[1] = go && (state_q != StIdle || !I_ready);
        set[2] = (state_q == StRun) && abort && !done_evt;
        sticky_d = (sticky_q & ~stat_clr) | set;

        cycles_d = cycles_q;
        if (state_q == StStart) begin
            cycles_d = '0;
        end else if (state_q == StRun && cycles_q != 32'hFFFF_FFFF) begin
            cycles_d = cycles_q + 32'd1;
        end

        start_d = (state_q == StStart);
    end

    // Registered host read data and core input word
    always_comb begin
        rdata_d = '0;
        case (addr_u)
            RegClkSettings: if (byte0) rdata_d = {3'b000, clk_q};
            RegUserLed:     if (byte0) rdata_d = {7'd0, led_q};
            RegCryptType:   if (byte0) rdata_d = 8'(pCRYPT_TYPE);
            RegCryptRev:    if (byte0) rdata_d = 8'(pCRYPT_REV);
            RegIdentify:    if (byte0) rdata_d = pIDENTIFY;
            RegCryptGo:     if (byte0) rdata_d = {7'd0, busy};
            RegStatus:      if (byte0) rdata_d = status_rd;
            RegCtrl:        if (byte0) rdata_d = {6'd0, ctrl_q};
            RegCycles: begin
                for (int b = 0; b < 4; b++) begin
                    if (bytecnt_u == 32'(b)) rdata_d = cycles_q[8*b +: 8];
                end
            end
            default: ;
        endcase
        for (int g = 0; g < int'(NumBanks); g++) begin
            if (g < int'(pNUM_IN)) begin
                if (byte_ok && addr_u == RegInBase + 32'(g)) rdata_d = bank_byte[g];
            end else begin
                if (byte_ok && addr_u == RegOutBase + 32'(g) - pNUM_IN) rdata_d = bank_byte[g];
            end
        end
        if (!rd_en) rdata_d = '0;

        in_word_d = '0;
        for (int g = 0; g < int'(pNUM_IN); g++) begin
            if (32'(in_sel) == 32'(g) && 32'(in_addr) < Words) in_word_d = bank_word[g];
        end
    end

    // State registers
    always_ff @(posedge crypto_clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata_q   <= '0;
            in_word_q <= '0;
            start_q   <= 1'b0;
            clk_q     <= '0;
            led_q     <= 1'b0;
            ctrl_q    <= '0;
            sticky_q  <= '0;
            cycles_q  <= '0;
            state_q   <= StIdle;
            done_in_q <= 1'b0;
            trig_q    <= '0;
        end else begin
            rdata_q   <= rdata_d;
            in_word_q <= in_word_d;
            start_q   <= start_d;
            clk_q     <= clk_d;
            led_q     <= led_d;
            ctrl_q    <= ctrl_d;
            sticky_q  <= sticky_d;
            cycles_q  <= cycles_d;
            state_q   <= state_d;
            done_in_q <= I_done;
            trig_q    <= {trig_q[1:0], exttrigger_in};
        end
    end

    assign read_data     = rdata_q;
    assign O_in_word     = in_word_q;
    assign O_start       = start_q;
    assign O_clksettings = clk_q;
    assign O_user_led    = led_q;

endmodule

// File: tb/tb_cw305_reg_pmul_gen.sv
// Directed bench for cw305_reg_pmul_gen with hand-computed expectations.
module tb_cw305_reg_pmul_gen;

    logic        crypto_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [12:0] reg_address = '0;
    logic [7:0]  reg_bytecnt = '0;
    logic        reg_read = 1'b0;
    logic        reg_write = 1'b0;
    logic        reg_addrvalid = 1'b0;
    logic [7:0]  write_data = '0;
    logic [7:0]  read_data;
    logic        exttrigger_in = 1'b0;
    logic        I_ready = 1'b1;
    logic        I_busy = 1'b0;
    logic        I_done = 1'b0;
    logic [1:0]  in_sel = '0;
    logic [2:0]  in_addr = '0;
    logic [31:0] O_in_word;
    logic        out_sel = 1'b0;
    logic [2:0]  out_addr = '0;
    logic        out_wren = 1'b0;
    logic [31:0] I_out_word = '0;
    logic        O_start;
    logic [4:0]  O_clksettings;
    logic        O_user_led;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;

    cw305_reg_pmul_gen dut (
        .crypto_clk    (crypto_clk),
        .reset_n       (reset_n),
        .reg_address   (reg_address),
        .reg_bytecnt   (reg_bytecnt),
        .reg_read      (reg_read),
        .reg_write     (reg_write),
        .reg_addrvalid (reg_addrvalid),
        .write_data    (write_data),
        .read_data     (read_data),
        .exttrigger_in (exttrigger_in),
        .I_ready       (I_ready),
        .I_busy        (I_busy),
        .I_done        (I_done),
        .in_sel        (in_sel),
        .in_addr       (in_addr),
        .O_in_word     (O_in_word),
        .out_sel       (out_sel),
        .out_addr      (out_addr),
        .out_wren      (out_wren),
        .I_out_word    (I_out_word),
        .O_start       (O_start),
        .O_clksettings (O_clksettings),
        .O_user_led    (O_user_led)
    );

    always #5 crypto_clk = ~crypto_clk;

    // Count O_start high cycles, sampled mid-cycle
    always @(negedge crypto_clk) begin
        if (O_start) start_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic reg_wr(input logic [12:0] a, input logic [7:0] b, input logic [7:0] d);
        @(posedge crypto_clk); #1;
        reg_address = a; reg_bytecnt = b; write_data = d;
        reg_write = 1'b1; reg_addrvalid = 1'b1;
        @(posedge crypto_clk); #1;
        reg_write = 1'b0; reg_addrvalid = 1'b0;
    endtask

    task automatic reg_rd(input logic [12:0] a, input logic [7:0] b, output logic [7:0] d);
        @(posedge crypto_clk); #1;
        reg_address = a; reg_bytecnt = b;
        reg_read = 1'b1; reg_addrvalid = 1'b1;
        @(posedge crypto_clk); #1;
        d = read_data;
        reg_read = 1'b0; reg_addrvalid = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [12:0] a, input logic [7:0] b,
                          input logic [7:0] exp);
        logic [7:0] d;
        reg_rd(a, b, d);
        check(tag, 32'(d), 32'(exp));
    endtask

    initial begin
        int s0;
        int first;
        int found;

        // Reset state
        repeat (3) @(posedge crypto_clk);
        #1;
        check("rst read_data", 32'(read_data), 32'h0);
        check("rst O_start", 32'(O_start), 32'h0);
        check("rst O_clksettings", 32'(O_clksettings), 32'h0);
        check("rst O_user_led", 32'(O_user_led), 32'h0);
        check("rst O_in_word", O_in_word, 32'h0);
        reset_n = 1'b1;

        // Read-only constants, idle status, unmapped index
        rd_chk("identify", 13'h04, 8'd0, 8'h2e);
        rd_chk("crypt_type", 13'h02, 8'd0, 8'h03);
        rd_chk("crypt_rev", 13'h03, 8'd0, 8'h03);
        rd_chk("status idle", 13'h06, 8'd0, 8'h10);
        rd_chk("unmapped", 13'h09, 8'd0, 8'h00);
        rd_chk("identify byte1", 13'h04, 8'd1, 8'h00);

        // Config registers
        reg_wr(13'h00, 8'd0, 8'h15);
        check("O_clksettings", 32'(O_clksettings), 32'h15);
        rd_chk("clksettings rd", 13'h00, 8'd0, 8'h15);
        reg_wr(13'h01, 8'd0, 8'h01);
        check("O_user_led", 32'(O_user_led), 32'h1);

        // Input bank 0 filled with byte index
        for (int i = 0; i < 32; i++) reg_wr(13'h10, 8'(i), 8'(i));
        in_sel = 2'd0; in_addr = 3'd1;
        @(posedge crypto_clk); #1;
        check("in_word k[1]", O_in_word, 32'h07060504);
        in_addr = 3'd7;
        @(posedge crypto_clk); #1;
        check("in_word k[7]", O_in_word, 32'h1F1E1D1C);
        rd_chk("bank0 byte31", 13'h10, 8'd31, 8'h1F);
        rd_chk("bank0 byte32", 13'h10, 8'd32, 8'h00);

        // Core writes result bank 1 word 0
        @(posedge crypto_clk); #1;
        out_sel = 1'b1; out_addr = 3'd0; I_out_word = 32'hDEADBEEF; out_wren = 1'b1;
        @(posedge crypto_clk); #1;
        out_wren = 1'b0;
        rd_chk("ry byte0", 13'h21, 8'd0, 8'hEF);
        rd_chk("ry byte3", 13'h21, 8'd3, 8'hDE);

        // Host-started job, done 40 cycles after O_start
        s0 = start_cnt;
        reg_wr(13'h05, 8'd0, 8'h00);
        found = 0;
        for (int k = 0; k < 10 && found == 0; k++) begin
            @(posedge crypto_clk); #1;
            if (O_start) found = 1;
        end
        check("job1 start seen", found, 1);
        repeat (40) @(posedge crypto_clk);
        #1;
        I_done = 1'b1;
        repeat (3) @(posedge crypto_clk);
        #1;
        I_done = 1'b0;
        check("job1 start pulses", start_cnt - s0, 1);
        rd_chk("status done", 13'h06, 8'd0, 8'h12);
        // 40 RUN cycles before I_done, plus the RUN cycle on which done is seen
        rd_chk("cycles b0", 13'h07, 8'd0, 8'd41);
        rd_chk("cycles b1", 13'h07, 8'd1, 8'h00);
        reg_wr(13'h06, 8'd0, 8'h02);
        rd_chk("status cleared", 13'h06, 8'd0, 8'h10);

        // Overrun, input lock and abort
        reg_wr(13'h05, 8'd0, 8'h00);
        reg_wr(13'h05, 8'd0, 8'h00);
        reg_wr(13'h11, 8'd0, 8'hAA);
        rd_chk("go busy", 13'h05, 8'd0, 8'h01);
        rd_chk("status overrun", 13'h06, 8'd0, 8'h15);
        rd_chk("locked gx", 13'h11, 8'd0, 8'h00);
        reg_wr(13'h08, 8'd0, 8'h04);
        rd_chk("status aborted", 13'h06, 8'd0, 8'h1C);
        rd_chk("ctrl after abort", 13'h08, 8'd0, 8'h00);
        rd_chk("go idle", 13'h05, 8'd0, 8'h00);
        reg_wr(13'h06, 8'd0, 8'h0E);
        rd_chk("status clr all", 13'h06, 8'd0, 8'h10);

        // External trigger with trig_en and clr_out_on_start
        reg_wr(13'h08, 8'd0, 8'h03);
        rd_chk("ctrl rd", 13'h08, 8'd0, 8'h03);
        s0 = start_cnt;
        @(posedge crypto_clk); #1;
        exttrigger_in = 1'b1;
        first = 0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge crypto_clk); #1;
            if (O_start && first == 0) first = k;
        end
        check("trig start latency", first, 4);
        check("trig start pulses", start_cnt - s0, 1);
        rd_chk("ry cleared", 13'h21, 8'd0, 8'h00);
        rd_chk("status trig run", 13'h06, 8'd0, 8'h11);
        @(posedge crypto_clk); #1;
        I_done = 1'b1;
        @(posedge crypto_clk); #1;
        I_done = 1'b0;
        repeat (2) @(posedge crypto_clk);
        rd_chk("status trig done", 13'h06, 8'd0, 8'h12);

        // Trigger disabled
        reg_wr(13'h08, 8'd0, 8'h00);
        exttrigger_in = 1'b0;
        repeat (4) @(posedge crypto_clk);
        #1;
        s0 = start_cnt;
        exttrigger_in = 1'b1;
        repeat (8) @(posedge crypto_clk);
        #1;
        check("trig disabled", start_cnt - s0, 0);
        exttrigger_in = 1'b0;

        // Reset in the middle of a job
        reg_wr(13'h05, 8'd0, 8'h00);
        repeat (3) @(posedge crypto_clk);
        #1;
        reg_address = 13'h04; reg_bytecnt = 8'd0; reg_read = 1'b1; reg_addrvalid = 1'b1;
        @(posedge crypto_clk); #1;
        check("pre-reset read", 32'(read_data), 32'h2e);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid rst read_data", 32'(read_data), 32'h0);
        check("mid rst O_in_word", O_in_word, 32'h0);
        check("mid rst O_clksettings", 32'(O_clksettings), 32'h0);
        check("mid rst O_user_led", 32'(O_user_led), 32'h0);
        check("mid rst O_start", 32'(O_start), 32'h0);
        reg_read = 1'b0; reg_addrvalid = 1'b0;
        @(negedge crypto_clk);
        reset_n = 1'b1;
        rd_chk("post rst status", 13'h06, 8'd0, 8'h10);
        rd_chk("post rst bank0", 13'h10, 8'd4, 8'h00);
        check("post rst in_word", O_in_word, 32'h0);
        rd_chk("post rst cycles", 13'h07, 8'd0, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
